// File: rtl/reshape_pkg.sv
// Shared encodings for the reshape sequencer: state codes seen on State_RE,
// one-hot op codes and the host clear command.
package reshape_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0000,
        ST_LOAD = 4'b0001,
        ST_DMA  = 4'b0010,
        ST_RUN  = 4'b0011,
        ST_ERR  = 4'b1110,
        ST_DONE = 4'b1111
    } re_state_e;

    localparam logic [3:0] OP_CONCAT   = 4'b0001;
    localparam logic [3:0] OP_ROUTE    = 4'b0010;
    localparam logic [3:0] OP_MAXPOOL  = 4'b0100;
    localparam logic [3:0] OP_UPSAMPLE = 4'b1000;
    localparam logic [3:0] CMD_CLEAR   = 4'b1111;
    localparam logic [3:0] SWITCH_RE   = 4'b1000;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/reshape_beat_calc.sv
// Combinational beat-count calculator: expected input/output beats for the
// latched op and geometry, plus a flag for illegal or unrepresentable jobs.
module reshape_beat_calc
    import reshape_pkg::*;
#(
    parameter int WIDTH_FEATURE_SIZE = 12,
    parameter int WIDTH_BEAT         = 32
) (
    input  logic [3:0]                    op_i,
    input  logic [WIDTH_FEATURE_SIZE-1:0] cols_i,
    input  logic [WIDTH_FEATURE_SIZE-1:0] groups_i,
    output logic [WIDTH_BEAT-1:0]         expected_in_o,
    output logic [WIDTH_BEAT-1:0]         expected_out_o,
    output logic                          err_o
);

    // Wide enough for cols*cols*groups*4 so overflow is detected, not wrapped.
    localparam int PW = 3 * WIDTH_FEATURE_SIZE + 2;

    logic [PW-1:0] cols_w;
    logic [PW-1:0] half_w;
    logic [PW-1:0] groups_w;
    logic [PW-1:0] in_total;
    logic [PW-1:0] out_total;

    always_comb begin
        cols_w    = PW'(cols_i);
        half_w    = PW'(cols_i >> 1);
        groups_w  = PW'(groups_i);
        in_total  = cols_w * cols_w * groups_w;
        out_total = in_total;
        case (op_i)
            OP_ROUTE:    out_total = in_total >> 1;
            OP_MAXPOOL:  out_total = half_w * half_w * groups_w;
            OP_UPSAMPLE: out_total = in_total << 2;
            default:     out_total = in_total;
        endcase
        err_o = (cols_i == '0) || (groups_i == '0)
             || ((op_i == OP_ROUTE) && groups_i[0])
             || ((in_total >> WIDTH_BEAT) != '0)
             || ((out_total >> WIDTH_BEAT) != '0);
        expected_in_o  = WIDTH_BEAT'(in_total);
        expected_out_o = WIDTH_BEAT'(out_total);
    end

endmodule

// File: rtl/reshape_ctrl.sv
// Reshape sequencer: decodes the host command, sizes the job, launches DMA,
// counts stream beats and reports progress on State_RE.
module reshape_ctrl
    import reshape_pkg::*;
#(
    parameter int WIDTH_FEATURE_SIZE = 12,
    parameter int WIDTH_BEAT         = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    Switch,
    input  logic [7:0]                    Control_RE,
    input  logic [31:0]                   Reg_7,
    input  logic                          S_Valid,
    input  logic                          S_Ready,
    input  logic                          M_Valid,
    input  logic                          M_Ready,
    output logic [3:0]                    State_RE,
    output logic                          DMA_Read_Start,
    output logic                          DMA_Write_Start,
    output logic                          RE_Start,
    output logic [3:0]                    RE_Op,
    output logic [WIDTH_FEATURE_SIZE-1:0] RE_Cols,
    output logic [WIDTH_FEATURE_SIZE-1:0] RE_Groups,
    output logic                          RE_Abort,
    output logic                          introut_RE
);

    // Streams are monitored only: a beat is a cycle with valid && ready high.

    re_state_e                     state_q;
    logic [3:0]                    op_q;
    logic [WIDTH_FEATURE_SIZE-1:0] cols_q;
    logic [WIDTH_FEATURE_SIZE-1:0] groups_q;
    logic [WIDTH_BEAT-1:0]         exp_in_q;
    logic [WIDTH_BEAT-1:0]         exp_out_q;
    logic [WIDTH_BEAT-1:0]         in_cnt_q;
    logic [WIDTH_BEAT-1:0]         out_cnt_q;
    logic                          rd_start_q;
    logic                          wr_start_q;
    logic                          re_start_q;
    logic                          abort_q;
    logic                          irq_q;

    logic [3:0]            cmd;
    logic                  cmd_clear;
    logic [WIDTH_BEAT-1:0] calc_in;
    logic [WIDTH_BEAT-1:0] calc_out;
    logic                  calc_err;
    logic                  unused_bits;

    assign cmd         = Control_RE[3:0];
    assign cmd_clear   = (cmd == CMD_CLEAR);
    assign unused_bits = ^{Control_RE[7:4], Reg_7};

    reshape_beat_calc #(
        .WIDTH_FEATURE_SIZE (WIDTH_FEATURE_SIZE),
        .WIDTH_BEAT         (WIDTH_BEAT)
    ) u_beat_calc (
        .op_i           (op_q),
        .cols_i         (cols_q),
        .groups_i       (groups_q),
        .expected_in_o  (calc_in),
        .expected_out_o (calc_out),
        .err_o          (calc_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            cols_q     <= '0;
            groups_q   <= '0;
            exp_in_q   <= '0;
            exp_out_q  <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
            re_start_q <= 1'b0;
            abort_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
            re_start_q <= 1'b0;
            abort_q    <= 1'b0;
            irq_q      <= 1'b0;
            // Clear outside IDLE: acknowledges DONE/ERR, aborts an active job.
            if (cmd_clear && (state_q != ST_IDLE)) begin
                abort_q   <= (state_q == ST_LOAD) || (state_q == ST_DMA) || (state_q == ST_RUN);
                state_q   <= ST_IDLE;
                op_q      <= '0;
                cols_q    <= '0;
                groups_q  <= '0;
                exp_in_q  <= '0;
                exp_out_q <= '0;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if ((Switch == SWITCH_RE) && is_onehot4(cmd)) begin
                            op_q      <= cmd;
                            cols_q    <= Reg_7[WIDTH_FEATURE_SIZE-1:0];
                            groups_q  <= Reg_7[16 +: WIDTH_FEATURE_SIZE];
                            in_cnt_q  <= '0;
                            out_cnt_q <= '0;
                            state_q   <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        exp_in_q  <= calc_in;
                        exp_out_q <= calc_out;
                        if (calc_err) begin
                            irq_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end else begin
                            // Launch pulses line up with the DMA state.
                            rd_start_q <= 1'b1;
                            wr_start_q <= 1'b1;
                            re_start_q <= 1'b1;
                            state_q    <= ST_DMA;
                        end
                    end
                    ST_DMA: state_q <= ST_RUN;
                    ST_RUN: begin
                        if (S_Valid && S_Ready && (in_cnt_q != exp_in_q)) begin
                            in_cnt_q <= in_cnt_q + 1'b1;
                        end
                        if (M_Valid && M_Ready && (out_cnt_q != exp_out_q)) begin
                            out_cnt_q <= out_cnt_q + 1'b1;
                        end
                        if ((in_cnt_q == exp_in_q) && (out_cnt_q == exp_out_q)) begin
                            irq_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_ERR, ST_DONE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign State_RE        = state_q;
    assign DMA_Read_Start  = rd_start_q;
    assign DMA_Write_Start = wr_start_q;
    assign RE_Start        = re_start_q;
    assign RE_Op           = op_q;
    assign RE_Cols         = cols_q;
    assign RE_Groups       = groups_q;
    assign RE_Abort        = abort_q;
    assign introut_RE      = irq_q;

endmodule

// File: tb/tb_reshape_ctrl.sv
// Directed bench for reshape_ctrl: terminal states are queued when a command is
// issued and matched against State_RE whenever introut_RE fires.
module tb_reshape_ctrl;
    import reshape_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  Switch = 4'b0000;
    logic [7:0]  Control_RE = 8'h00;
    logic [31:0] Reg_7 = 32'h0;
    logic        S_Valid = 1'b0, S_Ready = 1'b0, M_Valid = 1'b0, M_Ready = 1'b0;
    logic [3:0]  State_RE;
    logic        DMA_Read_Start, DMA_Write_Start, RE_Start, RE_Abort, introut_RE;
    logic [3:0]  RE_Op;
    logic [11:0] RE_Cols, RE_Groups;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_q[$];
    logic [3:0] dropped;

    reshape_ctrl #(.WIDTH_FEATURE_SIZE(12), .WIDTH_BEAT(32)) dut (
        .clk(clk), .rst(rst), .Switch(Switch), .Control_RE(Control_RE), .Reg_7(Reg_7),
        .S_Valid(S_Valid), .S_Ready(S_Ready), .M_Valid(M_Valid), .M_Ready(M_Ready),
        .State_RE(State_RE), .DMA_Read_Start(DMA_Read_Start), .DMA_Write_Start(DMA_Write_Start),
        .RE_Start(RE_Start), .RE_Op(RE_Op), .RE_Cols(RE_Cols), .RE_Groups(RE_Groups),
        .RE_Abort(RE_Abort), .introut_RE(introut_RE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every interrupt consumes one queued terminal state.
    always @(negedge clk) begin
        if (introut_RE) begin
            if (exp_q.size() == 0) begin
                check("irq_unexpected", 64'(introut_RE), 64'd0);
            end else begin
                check("irq_state", 64'(State_RE), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [31:0] r7,
                          input bit exp_err);
        Switch = SWITCH_RE;
        Control_RE = {4'hA, op};
        Reg_7 = r7;
        exp_q.push_back(exp_err ? ST_ERR : ST_DONE);
        tick();
        Control_RE = 8'h00;
        Switch = 4'($urandom_range(0, 15));
        Reg_7 = $urandom;
        check({tag, "_load"}, 64'(State_RE), 64'(ST_LOAD));
        check({tag, "_load_nopulse"}, 64'({DMA_Read_Start, DMA_Write_Start, RE_Start}), 64'd0);
        tick();
        if (exp_err) begin
            check({tag, "_err"}, 64'(State_RE), 64'(ST_ERR));
            check({tag, "_err_irq"}, 64'(introut_RE), 64'd1);
            check({tag, "_err_nodma"}, 64'({DMA_Read_Start, DMA_Write_Start, RE_Start}), 64'd0);
        end else begin
            check({tag, "_dma"}, 64'(State_RE), 64'(ST_DMA));
            check({tag, "_dma_pulses"}, 64'({DMA_Read_Start, DMA_Write_Start, RE_Start}), 64'd7);
            check({tag, "_op"}, 64'(RE_Op), 64'(op));
            check({tag, "_geom"}, 64'({RE_Groups, RE_Cols}), 64'({r7[27:16], r7[11:0]}));
            tick();
            check({tag, "_run"}, 64'(State_RE), 64'(ST_RUN));
            check({tag, "_run_nopulse"}, 64'({DMA_Read_Start, DMA_Write_Start, RE_Start}), 64'd0);
        end
    endtask

    task automatic stream(input string tag, input int n_in, input int n_out, input bit stall);
        int gi = 0;
        int go = 0;
        int cyc = 0;
        while ((gi < n_in || go < n_out) && cyc < 2 * (n_in + n_out) + 200) begin
            S_Valid = (gi < n_in) && (!stall || $urandom_range(0, 3) != 0);
            S_Ready = !stall || $urandom_range(0, 3) != 0;
            M_Valid = (go < n_out) && (!stall || $urandom_range(0, 3) != 0);
            M_Ready = !stall || $urandom_range(0, 3) != 0;
            tick();
            if (S_Valid && S_Ready) gi++;
            if (M_Valid && M_Ready) go++;
            cyc++;
        end
        {S_Valid, S_Ready, M_Valid, M_Ready} = 4'b0;
        check({tag, "_stream_budget"}, 64'({gi, go}), 64'({n_in, n_out}));
    endtask

    task automatic finish_done(input string tag);
        check({tag, "_still_run"}, 64'(State_RE), 64'(ST_RUN));
        tick();
        check({tag, "_done"}, 64'(State_RE), 64'(ST_DONE));
        check({tag, "_done_irq"}, 64'(introut_RE), 64'd1);
        tick();
        check({tag, "_irq_once"}, 64'({State_RE, introut_RE}), 64'({ST_DONE, 1'b0}));
    endtask

    task automatic clear(input string tag);
        Control_RE = {4'h0, CMD_CLEAR};
        tick();
        Control_RE = 8'h00;
        check({tag, "_clear_idle"}, 64'(State_RE), 64'(ST_IDLE));
        check({tag, "_clear_regs"}, 64'({RE_Op, RE_Cols, RE_Groups, RE_Abort}), 64'd0);
    endtask

    task automatic abort_active(input string tag);
        Control_RE = {4'h0, CMD_CLEAR};
        tick();
        Control_RE = 8'h00;
        check({tag, "_abort_idle"}, 64'(State_RE), 64'(ST_IDLE));
        check({tag, "_abort_pulse"}, 64'(RE_Abort), 64'd1);
        check({tag, "_abort_op"}, 64'(RE_Op), 64'd0);
        dropped = exp_q.pop_front();
        tick();
        check({tag, "_abort_once"}, 64'(RE_Abort), 64'd0);
    endtask

    initial begin
        // Reset values.
        #1;
        check("reset_state", 64'(State_RE), 64'(ST_IDLE));
        check("reset_outs", 64'({DMA_Read_Start, DMA_Write_Start, RE_Start, RE_Op, RE_Cols,
                                 RE_Groups, RE_Abort, introut_RE}), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Commands that must be ignored in IDLE.
        Switch = SWITCH_RE; Control_RE = 8'h03; Reg_7 = 32'h0004_0034;
        tick();
        check("ign_not_onehot", 64'(State_RE), 64'(ST_IDLE));
        Switch = 4'b0001; Control_RE = 8'h02;
        tick();
        check("ign_switch", 64'(State_RE), 64'(ST_IDLE));
        Switch = SWITCH_RE; Control_RE = 8'h0F;
        tick();
        check("ign_clear_idle", 64'({State_RE, RE_Abort}), 64'd0);
        Control_RE = 8'h00;
        tick();

        // Route 52x52x4: 10816 in, 5408 out; a mid-run command is ignored.
        do_cmd("route", OP_ROUTE, 32'h0004_0034, 1'b0);
        Control_RE = {4'h0, OP_MAXPOOL};
        tick();
        Control_RE = 8'h00;
        check("route_ign_cmd", 64'({State_RE, RE_Op}), 64'({ST_RUN, OP_ROUTE}));
        stream("route", 10816, 5407, 1'b0);
        stream("route_last", 0, 1, 1'b0);
        finish_done("route");
        clear("route");

        // Maxpool 52x52x4 -> 2704 out; surplus input beats must saturate.
        do_cmd("mp52", OP_MAXPOOL, 32'h0004_0034, 1'b0);
        stream("mp52", 10821, 2703, 1'b0);
        check("mp52_not_early", 64'(State_RE), 64'(ST_RUN));
        tick();
        check("mp52_wait", 64'(State_RE), 64'(ST_RUN));
        stream("mp52_last", 0, 1, 1'b0);
        finish_done("mp52");
        clear("mp52");

        // Maxpool 53x53x1 -> floor(53/2)^2 = 676 out, 2809 in, with stalls.
        do_cmd("mp53", OP_MAXPOOL, 32'h0001_0035, 1'b0);
        stream("mp53", 2809, 675, 1'b1);
        stream("mp53_last", 0, 1, 1'b0);
        finish_done("mp53");
        clear("mp53");

        // Upsample 52x52x4 -> 43264 out.
        do_cmd("ups", OP_UPSAMPLE, 32'h0004_0034, 1'b0);
        stream("ups", 10816, 43263, 1'b0);
        stream("ups_last", 0, 1, 1'b0);
        finish_done("ups");
        clear("ups");

        // Concat 8x8x3: output beats saturate, completion waits on the input side.
        do_cmd("cat", OP_CONCAT, 32'h0003_0008, 1'b0);
        stream("cat", 191, 195, 1'b1);
        stream("cat_last", 1, 0, 1'b0);
        finish_done("cat");
        clear("cat");

        // Error paths: odd route groups, zero cols, upsample product >= 2^32.
        do_cmd("odd", OP_ROUTE, 32'h0003_0034, 1'b1);
        tick();
        check("odd_hold", 64'({State_RE, introut_RE}), 64'({ST_ERR, 1'b0}));
        clear("odd");
        do_cmd("zcol", OP_CONCAT, 32'h0004_0000, 1'b1);
        clear("zcol");
        do_cmd("ovf", OP_UPSAMPLE, 32'h0100_0FFF, 1'b1);
        clear("ovf");

        // Largest concat that still fits 32 bits; aborted in RUN.
        do_cmd("big", OP_CONCAT, 32'h0100_0FFF, 1'b0);
        abort_active("big");

        // Abort while in LOAD.
        Switch = SWITCH_RE; Control_RE = {4'h0, OP_ROUTE}; Reg_7 = 32'h0002_0010;
        tick();
        Control_RE = {4'h0, CMD_CLEAR};
        tick();
        Control_RE = 8'h00;
        check("ld_abort", 64'({State_RE, RE_Abort, DMA_Read_Start}), 64'({ST_IDLE, 1'b1, 1'b0}));
        tick();

        // Abort at out_cnt=100, then a fresh route must count from zero.
        do_cmd("ab", OP_ROUTE, 32'h0002_0010, 1'b0);
        stream("ab", 200, 100, 1'b1);
        abort_active("ab");
        do_cmd("re", OP_ROUTE, 32'h0002_0004, 1'b0);
        stream("re", 31, 16, 1'b1);
        stream("re_last", 1, 0, 1'b0);
        finish_done("re");
        clear("re");

        // Asynchronous reset mid-RUN, then a normal route.
        do_cmd("rst", OP_ROUTE, 32'h0002_0008, 1'b0);
        stream("rst", 50, 20, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_state", 64'(State_RE), 64'(ST_IDLE));
        check("async_rst_outs", 64'({DMA_Read_Start, DMA_Write_Start, RE_Start, RE_Op, RE_Cols,
                                     RE_Groups, RE_Abort, introut_RE}), 64'd0);
        dropped = exp_q.pop_front();
        tick();
        rst = 1'b1;
        tick();
        do_cmd("post", OP_ROUTE, 32'h0002_0008, 1'b0);
        stream("post", 128, 63, 1'b1);
        stream("post_last", 0, 1, 1'b0);
        finish_done("post");
        clear("post");

        tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
